md_issue_ctrl: RTL and testbench

- Issue and hazard controller that sits directly upstream of the HI/LO multiply-divide unit in the E stage.
- Gates E-stage mult/multu/div/divu/mthi/mtlo requests into the unit and suppresses them on pipeline flush.
- Tracks the unit's fixed latency with its own counter and raises the D-stage stall for any HI/LO-class instruction while a computation is outstanding.
- Also provides a desync check against the unit's busy flag and a stall-cycle performance counter.

---
 rtl/md_issue_ctrl_pkg.sv | 25 ++
 rtl/md_issue_ctrl_lat_counter.sv | 37 +++
 rtl/md_issue_ctrl.sv | 116 +++++++++++
 tb/tb_md_issue_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/md_issue_ctrl_pkg.sv
// Shared constants for the HI/LO multiply-divide path: op codes, tracker state
// encodings and default latencies.
package md_issue_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;

  localparam logic [1:0] MD_IDLE     = 2'd0;
  localparam logic [1:0] MD_MUL_WAIT = 2'd1;
  localparam logic [1:0] MD_DIV_WAIT = 2'd2;

  localparam int MUL_LAT_DEF = 6;
  localparam int DIV_LAT_DEF = 11;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_lat_counter.sv
// Loadable down-counter with zero detect; holds at zero once it gets there.
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue gate and fixed-latency hazard tracker in front of the HI/LO
// multiply-divide unit; also cross-checks the unit's busy flag.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_md_start,
  input  logic        e_mthi,
  input  logic        e_mtlo,
  input  logic [2:0]  e_md_op,
  input  logic        flush,
  input  logic        d_md_use,
  input  logic        md_busy,
  output logic        md_start,
  output logic        md_mthi,
  output logic        md_mtlo,
  output logic [2:0]  md_op,
  output logic        stall_d,
  output logic        desync,
  output logic [31:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  logic [1:0]       state_q, state_d;
  logic             started_q, started_d;
  logic             desync_q, desync_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic [CNT_W-1:0] load_val;
  logic             idle, issue, mul_issue, div_issue;
  logic             busy_expected, mismatch;

  // Handshake: md_start/md_mthi/md_mtlo are single-cycle pulses taken by the
  // unit on the next rising edge; they are only ever raised while the tracker
  // is idle, and the unit raises busy one edge after accepting a start.
  assign idle      = (state_q == MD_IDLE);
  assign issue     = e_md_start & ~flush & idle;
  assign mul_issue = issue & is_mul_op(e_md_op);
  assign div_issue = issue & is_div_op(e_md_op);

  assign md_start  = issue;
  assign md_mthi   = e_mthi & ~flush & idle;
  assign md_mtlo   = e_mtlo & ~flush & idle;
  assign md_op     = e_md_op;
  assign stall_d   = d_md_use & (issue | ~idle);
  assign load_val  = mul_issue ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);

  md_lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (mul_issue | div_issue),
    .load_val (load_val),
    .dec      (~idle),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: begin
        if (mul_issue)      state_d = MD_MUL_WAIT;
        else if (div_issue) state_d = MD_DIV_WAIT;
      end
      MD_MUL_WAIT, MD_DIV_WAIT: begin
        if ((cnt == CNT_W'(1)) || cnt_zero) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Busy is only checked strictly inside the wait: the first wait cycle and
  // the final one are left alone so edge skew in the unit is tolerated.
  always_comb begin
    busy_expected = 1'b0;
    if (state_q == MD_MUL_WAIT) begin
      busy_expected = (cnt != CNT_W'(MUL_LAT - 1)) && (cnt >= CNT_W'(2));
    end else if (state_q == MD_DIV_WAIT) begin
      busy_expected = (cnt != CNT_W'(DIV_LAT - 1)) && (cnt >= CNT_W'(2));
    end
  end

  always_comb begin
    mismatch    = (busy_expected & ~md_busy)
                | (idle & ~started_q & md_busy)
                | (e_md_start & ~idle);
    started_d   = mul_issue | div_issue;
    desync_d    = desync_q | mismatch;
    stall_cnt_d = stall_cnt_q + 32'(stall_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MD_IDLE;
      started_q   <= 1'b0;
      desync_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      desync_q    <= desync_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign desync    = desync_q;
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: per-cycle expected outputs are queued by the
// driver and checked on the falling edge by an independent monitor.
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  localparam int W = 42;

  logic        clk;
  logic        reset;
  logic        e_md_start, e_mthi, e_mtlo, flush, d_md_use, md_busy;
  logic [2:0]  e_md_op;
  logic        md_start, md_mthi, md_mtlo, stall_d, desync;
  logic [2:0]  md_op;
  logic [31:0] stall_cnt;
  logic [1:0]  dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] exp_stall_cnt;

  md_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .e_md_start (e_md_start),
    .e_mthi     (e_mthi),
    .e_mtlo     (e_mtlo),
    .e_md_op    (e_md_op),
    .flush      (flush),
    .d_md_use   (d_md_use),
    .md_busy    (md_busy),
    .md_start   (md_start),
    .md_mthi    (md_mthi),
    .md_mtlo    (md_mtlo),
    .md_op      (md_op),
    .stall_d    (stall_d),
    .desync     (desync),
    .stall_cnt  (stall_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Driver: apply one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input logic st, input logic th, input logic tl, input logic [2:0] op,
                      input logic fl, input logic use_d, input logic busy,
                      input logic x_start, input logic x_mthi, input logic x_mtlo,
                      input logic x_stall, input logic [1:0] x_state, input logic x_desync);
    e_md_start = st;
    e_mthi     = th;
    e_mtlo     = tl;
    e_md_op    = op;
    flush      = fl;
    d_md_use   = use_d;
    md_busy    = busy;
    exp_q.push_back({x_start, x_mthi, x_mtlo, x_stall, x_state, x_desync, exp_stall_cnt, op});
    if (x_stall) exp_stall_cnt = exp_stall_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("md_start",  32'(md_start),  32'(e[41]));
      check("md_mthi",   32'(md_mthi),   32'(e[40]));
      check("md_mtlo",   32'(md_mtlo),   32'(e[39]));
      check("stall_d",   32'(stall_d),   32'(e[38]));
      check("state",     32'(dbg_state), 32'(e[37:36]));
      check("desync",    32'(desync),    32'(e[35]));
      check("stall_cnt", stall_cnt,      e[34:3]);
      check("md_op",     32'(md_op),     32'(e[2:0]));
    end
  end

  initial begin
    reset = 1'b0;
    e_md_start = 0; e_mthi = 0; e_mtlo = 0; e_md_op = OP_MULT;
    flush = 0; d_md_use = 0; md_busy = 0;
    exp_stall_cnt = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_state",     32'(dbg_state), 32'(MD_IDLE));
    check("rst_stall_cnt", stall_cnt,      32'd0);
    check("rst_desync",    32'(desync),    32'd0);
    reset = 1'b1;

    // mult with D-stage HI/LO use throughout: stall cycles 0..5
    step(1,0,0,OP_MULT,0,1,0, 1,0,0,1,MD_IDLE,0);
    for (int i = 1; i <= 5; i++) step(0,0,0,OP_MULT,0,1,1, 0,0,0,1,MD_MUL_WAIT,0);
    step(0,0,0,OP_MULT,0,1,0, 0,0,0,0,MD_IDLE,0);
    step(0,0,0,OP_MULT,0,0,0, 0,0,0,0,MD_IDLE,0);

    // divu: stall cycles 0..10, idle at cycle 11
    step(1,0,0,OP_DIVU,0,1,0, 1,0,0,1,MD_IDLE,0);
    for (int i = 1; i <= 10; i++) step(0,0,0,OP_DIVU,0,1,1, 0,0,0,1,MD_DIV_WAIT,0);
    step(0,0,0,OP_DIVU,0,1,0, 0,0,0,0,MD_IDLE,0);

    // flushed start, then mflo in D
    step(1,0,0,OP_MULT,1,1,0, 0,0,0,0,MD_IDLE,0);
    step(0,0,0,OP_MULT,0,1,0, 0,0,0,0,MD_IDLE,0);

    // mthi / mtlo while idle, mthi killed by flush
    step(0,1,0,OP_MULTU,0,0,0, 0,1,0,0,MD_IDLE,0);
    step(0,0,1,OP_MULTU,0,1,0, 0,0,1,0,MD_IDLE,0);
    step(0,1,0,OP_MULTU,1,0,0, 0,0,0,0,MD_IDLE,0);

    // unknown op: start is passed but no wait is entered
    step(1,0,0,3'd5,0,0,0, 1,0,0,0,MD_IDLE,0);
    step(0,0,0,3'd5,0,1,0, 0,0,0,0,MD_IDLE,0);

    // start and mthi during MUL_WAIT are gated and flag desync
    step(1,0,0,OP_MULT,0,1,0, 1,0,0,1,MD_IDLE,0);
    step(0,0,0,OP_MULT,0,1,1, 0,0,0,1,MD_MUL_WAIT,0);
    step(1,1,0,OP_MULT,0,1,1, 0,0,0,1,MD_MUL_WAIT,0);
    for (int i = 3; i <= 5; i++) step(0,0,0,OP_MULT,0,1,1, 0,0,0,1,MD_MUL_WAIT,1);
    step(0,0,0,OP_MULT,0,0,0, 0,0,0,0,MD_IDLE,1);

    // div interrupted by asynchronous reset at cycle 4
    step(1,0,0,OP_DIV,0,1,0, 1,0,0,1,MD_IDLE,1);
    for (int i = 1; i <= 3; i++) step(0,0,0,OP_DIV,0,1,1, 0,0,0,1,MD_DIV_WAIT,1);
    e_md_start = 0; e_mthi = 1; d_md_use = 1; md_busy = 1;
    #2 reset = 1'b0;
    #1;
    check("arst_state",     32'(dbg_state), 32'(MD_IDLE));
    check("arst_stall_d",   32'(stall_d),   32'd0);
    check("arst_stall_cnt", stall_cnt,      32'd0);
    check("arst_desync",    32'(desync),    32'd0);
    check("arst_md_mthi",   32'(md_mthi),   32'd1);
    exp_stall_cnt = 32'd0;
    @(posedge clk);
    #1;
    e_mthi = 0; md_busy = 0; d_md_use = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // fresh mult after reset completes in 6 cycles
    step(1,0,0,OP_MULTU,0,1,0, 1,0,0,1,MD_IDLE,0);
    for (int i = 1; i <= 5; i++) step(0,0,0,OP_MULTU,0,1,1, 0,0,0,1,MD_MUL_WAIT,0);
    step(0,0,0,OP_MULTU,0,1,0, 0,0,0,0,MD_IDLE,0);

    // busy dropped in DIV_WAIT cycle 3; stall timing unchanged, desync sticks
    step(1,0,0,OP_DIV,0,1,0, 1,0,0,1,MD_IDLE,0);
    for (int i = 1; i <= 10; i++) begin
      logic u;
      u = logic'(i % 2);
      step(0,0,0,OP_DIV,0,u,(i != 3), 0,0,0,u,MD_DIV_WAIT,(i >= 4));
    end
    step(0,0,0,OP_DIV,0,1,0, 0,0,0,0,MD_IDLE,1);
    step(0,0,0,OP_DIV,0,0,0, 0,0,0,0,MD_IDLE,1);

    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("final_rst_desync", 32'(desync), 32'd0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
